compute_request_arbiter: RTL
============================

COMPUTE_REQUEST_ARBITER -- requirements
Module: compute_request_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 4, SHALL set the number of requesting units; the width of unit_id is fixed at 2, so the maximum is 4.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of WAIT cycles before an error return.
REQ-003 Ports SHALL be:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  cli_req  in  NUM_CLIENTS  per-client request, level
  cli_type  in  comp_type_e[NUM_CLIENTS]  per-client operation
  cli_vec_a / cli_vec_b  in  vector_t[NUM_CLIENTS]  per-client operands
  cli_mat  in  matrix_t[NUM_CLIENTS]  per-client matrix
  cli_gnt  out  NUM_CLIENTS  one-hot grant pulse
  cli_done  out  NUM_CLIENTS  one-hot completion pulse
  cli_err  out  1  timeout flag, valid with cli_done
  cli_result  out  vector_t  returned result
  su_ready  in  1  compute unit idle
  su_done  in  1  compute unit done
  su_result  in  vector_t  compute unit result
  su_request  out  1  request to compute unit
  su_unit_id  out  2  granted client index
  su_comp_type  out  comp_type_e  latched operation
  su_vector_a / su_vector_b  out  vector_t  latched operands
  su_matrix  out  matrix_t  latched matrix

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RETURN; all outputs SHALL be registered.
REQ-005 IDLE: when su_ready=1 and any cli_req bit=1, the block SHALL select client k by round-robin, starting from the index one above last_grant and wrapping at NUM_CLIENTS; it SHALL then latch that client's type and operands, and enter ISSUE.
REQ-006 IDLE with su_ready=0 SHALL issue no grant, whatever cli_req holds.
REQ-007 ISSUE SHALL last exactly 1 cycle, with cli_gnt[k]=1, su_request=1 and su_unit_id=k; it SHALL then enter WAIT.
REQ-008 The su_* operand outputs SHALL hold the latched values unchanged from ISSUE through RETURN, so a client may change its inputs after cli_gnt.
REQ-009 WAIT SHALL detect a completion as a rising edge of su_done (su_done=1 and the previous sample 0); a su_done level held over from an earlier job SHALL be ignored.
REQ-010 On a completion edge the block SHALL capture su_result into cli_result and enter RETURN with cli_err=0.
REQ-011 The WAIT cycle counter SHALL reset on entry to WAIT; if it reaches TIMEOUT_CYCLES-1 with no completion edge, the block SHALL enter RETURN with cli_err=1 and cli_result=0.
REQ-012 RETURN SHALL last exactly 1 cycle, with cli_done[k]=1, and SHALL set last_grant=k before entering IDLE.
REQ-013 cli_result and cli_err SHALL hold their values until the next RETURN.
REQ-014 Latency: a request seen in IDLE at cycle N SHALL produce the grant at N+1; a completion edge at cycle M SHALL produce cli_done at M+1; the next grant SHALL come no earlier than M+3.
REQ-015 A cli_req deasserted before its grant SHALL be dropped without side effects.
REQ-016 Requests arriving while the FSM is not in IDLE SHALL wait and be arbitrated in the next IDLE cycle.
REQ-017 At most one cli_gnt bit and one cli_done bit SHALL be high in any cycle.

Reset
REQ-018 While rst_n=0, the state SHALL be IDLE and cli_gnt, cli_done, cli_err, su_request, su_unit_id, cli_result, the su_* operands and the timeout counter SHALL all be 0.
REQ-019 last_grant SHALL reset to NUM_CLIENTS-1, so client 0 has first priority.
REQ-020 A reset asserted mid-transaction SHALL abandon the transaction with no cli_done pulse.

Structure
REQ-021 comp_type_e, vector_t and matrix_t SHALL come from accel_pkg; arb_state_e and ARB_TIMEOUT_DEFAULT SHALL be added to accel_pkg.
REQ-022 The round-robin selection SHALL be a combinational sub-module named rr_priority_picker (inputs: request vector and last_grant; outputs: valid and index).

Verification
REQ-023 Client 2 requests COMP_ADD with a={1,2,..}, b={10,..}, and the responder asserts su_done 20 cycles after su_request -> cli_gnt=0100, su_unit_id=2, cli_done=0100 one cycle after the done edge, cli_result equals su_result, cli_err=0.
REQ-024 All four clients request continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-025 su_done held high from the prior job and su_ready=1 -> no completion until a fresh rising edge; with TIMEOUT_CYCLES=8 and no edge -> cli_done pulse, cli_err=1, cli_result=0.
REQ-026 su_ready=0 with cli_req=1111 -> no cli_gnt and no su_request for 10 cycles; su_ready rises -> grant to client 0 the next cycle.
REQ-027 Client operands changed the cycle after grant -> su_vector_a/su_matrix unchanged until RETURN.
REQ-028 rst_n pulsed low during WAIT -> all outputs 0, no cli_done pulse, next grant goes to client 0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator types: operation codes, operand shapes, and the
// compute-request arbiter's state encoding and default timeout.
package accel_pkg;

    localparam int VEC_LEN = 4;
    localparam int ELEM_W  = 8;

    typedef enum logic [1:0] {
        COMP_ADD    = 2'd0,
        COMP_SUB    = 2'd1,
        COMP_MUL    = 2'd2,
        COMP_MATVEC = 2'd3
    } comp_type_e;

    typedef logic [VEC_LEN-1:0][ELEM_W-1:0]              vector_t;
    typedef logic [VEC_LEN-1:0][VEC_LEN-1:0][ELEM_W-1:0] matrix_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RETURN = 2'd3
    } arb_state_e;

    // Default number of WAIT cycles before a job is returned with an error.
    localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting at
// the index one above last_grant and wrapping, returns the first hit.
module rr_priority_picker #(
    parameter int NUM_CLIENTS = 4
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [1:0]             last_grant,
    output logic                   valid,
    output logic [1:0]             idx
);

    // (base + offset) modulo NUM_CLIENTS; base < NUM_CLIENTS and
    // offset <= NUM_CLIENTS, so one conditional subtraction suffices.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int unsigned offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(NUM_CLIENTS)) begin
            sum = sum - 32'(NUM_CLIENTS);
        end
        return sum[1:0];
    endfunction

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester above last_grant is the one left in idx.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            if (req[wrap_idx(last_grant, 32'(i))]) begin
                valid = 1'b1;
                idx   = wrap_idx(last_grant, 32'(i));
            end
        end
    end

endmodule

// File: rtl/compute_request_arbiter.sv
// Compute request arbiter: shares one compute unit between NUM_CLIENTS
// requesters. One job at a time: pick a client round-robin, latch its
// operation and operands, issue to the compute unit, wait for completion or
// timeout, and return the result to the client.
//
// Handshakes: cli_req is a level held by the client until it sees its
// one-cycle cli_gnt pulse; dropping it earlier withdraws the request. The
// job is finished by a one-cycle cli_done pulse to the same client, with
// cli_result/cli_err valid then and held until the next return.
// Toward the compute unit, su_request is a one-cycle pulse sent only while
// su_ready=1 was seen in IDLE; the unit signals completion with a rising
// edge of su_done, so a level left high from a prior job never completes
// a new one.
module compute_request_arbiter
    import accel_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CLIENTS-1:0]       cli_req,
    input  comp_type_e [NUM_CLIENTS-1:0] cli_type,
    input  vector_t [NUM_CLIENTS-1:0]    cli_vec_a,
    input  vector_t [NUM_CLIENTS-1:0]    cli_vec_b,
    input  matrix_t [NUM_CLIENTS-1:0]    cli_mat,
    output logic [NUM_CLIENTS-1:0]       cli_gnt,
    output logic [NUM_CLIENTS-1:0]       cli_done,
    output logic                         cli_err,
    output vector_t                      cli_result,
    input  logic                         su_ready,
    input  logic                         su_done,
    input  vector_t                      su_result,
    output logic                         su_request,
    output logic [1:0]                   su_unit_id,
    output comp_type_e                   su_comp_type,
    output vector_t                      su_vector_a,
    output vector_t                      su_vector_b,
    output matrix_t                      su_matrix
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state;
    arb_state_e             next_state;
    logic [1:0]             last_grant;
    logic [1:0]             grant_idx;
    logic                   pick_valid;
    logic [1:0]             pick_idx;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   su_done_q;
    logic                   done_edge;
    logic                   timeout_hit;
    logic                   start_job;
    logic                   end_job;
    logic [NUM_CLIENTS-1:0] gnt_d;
    logic [NUM_CLIENTS-1:0] done_d;
    logic                   request_d;

    rr_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_picker (
        .req        (cli_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign done_edge   = su_done & ~su_done_q;
    assign timeout_hit = (wait_cnt == CNT_LAST);
    assign start_job   = (state == ARB_IDLE) && (next_state == ARB_ISSUE);
    assign end_job     = (state == ARB_WAIT) && (next_state == ARB_RETURN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: ISSUE and RETURN are always single cycles.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:   if (su_ready && pick_valid) next_state = ARB_ISSUE;
            ARB_ISSUE:  next_state = ARB_WAIT;
            ARB_WAIT:   if (done_edge || timeout_hit) next_state = ARB_RETURN;
            ARB_RETURN: next_state = ARB_IDLE;
            default:    next_state = ARB_IDLE;
        endcase
    end

    // Output decode: pulses for the state being entered, registered below.
    always_comb begin
        gnt_d     = '0;
        done_d    = '0;
        request_d = 1'b0;
        if (start_job) begin
            gnt_d[pick_idx] = 1'b1;
            request_d       = 1'b1;
        end
        if (end_job) begin
            done_d[grant_idx] = 1'b1;
        end
    end

    // Output and datapath registers; operands are captured once per job so
    // the client may change its inputs as soon as it is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cli_gnt      <= '0;
            cli_done     <= '0;
            cli_err      <= 1'b0;
            cli_result   <= '0;
            su_request   <= 1'b0;
            su_unit_id   <= 2'd0;
            su_comp_type <= COMP_ADD;
            su_vector_a  <= '0;
            su_vector_b  <= '0;
            su_matrix    <= '0;
            grant_idx    <= 2'd0;
            last_grant   <= 2'(NUM_CLIENTS - 1);
            wait_cnt     <= '0;
            su_done_q    <= 1'b0;
        end else begin
            cli_gnt    <= gnt_d;
            cli_done   <= done_d;
            su_request <= request_d;
            su_done_q  <= su_done;

            if (start_job) begin
                grant_idx    <= pick_idx;
                su_unit_id   <= pick_idx;
                su_comp_type <= cli_type[pick_idx];
                su_vector_a  <= cli_vec_a[pick_idx];
                su_vector_b  <= cli_vec_b[pick_idx];
                su_matrix    <= cli_mat[pick_idx];
            end

            // Counter starts from zero on the first WAIT cycle.
            if (state == ARB_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ARB_WAIT && !end_job) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // A completion edge wins over a timeout in the same cycle.
            if (end_job) begin
                cli_result <= done_edge ? su_result : '0;
                cli_err    <= ~done_edge;
            end

            if (state == ARB_RETURN) begin
                last_grant <= grant_idx;
            end
        end
    end

endmodule
